// File: rtl/usbfs_packet_parser.sv
// USB full-speed packet parser: consumes de-stuffed bits LSB-first and classifies each packet by PID.
// It extracts token/SOF fields, streams data payload and reports a per-packet status at end of packet.
module usbfs_packet_parser #(
  parameter int MAX_DATA  = 64,
  parameter int STRIP_CRC = 1,
  parameter int LW        = $clog2(MAX_DATA + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_sta,
  input  logic          rx_ena,
  input  logic          rx_bit,
  input  logic          rx_fin,
  output logic [3:0]    rp_pid,
  output logic [6:0]    rp_addr,
  output logic [3:0]    rp_endp,
  output logic [10:0]   rp_frame,
  output logic          rp_byte_en,
  output logic [7:0]    rp_byte,
  output logic          rp_fin,
  output logic          rp_okay,
  output logic [3:0]    rp_err,
  output logic [LW-1:0] rp_len
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PID = 2'd1, S_BODY = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [10:0]   nbody_q, nbody_d;
  logic          pid_ok_q, pid_ok_d;
  logic          ovf_q, ovf_d;
  logic [4:0]    crc5_q, crc5_d;
  logic [15:0]   crc16_q, crc16_d;
  logic [7:0]    b0_q, b0_d;
  logic [7:0]    dl0_q, dl0_d;
  logic [7:0]    dl1_q, dl1_d;
  logic [LW-1:0] ecnt_q, ecnt_d;
  logic [3:0]    pid_q, pid_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [10:0]   frame_q, frame_d;
  logic          byte_en_q, byte_en_d;
  logic [7:0]    byte_q, byte_d;
  logic          fin_q, fin_d;
  logic          okay_q, okay_d;
  logic [3:0]    err_q, err_d;
  logic [LW-1:0] len_q, len_d;

  logic          take_bit;
  logic [7:0]    new_sh;
  logic [4:0]    crc5_nx;
  logic [15:0]   crc16_nx;
  logic          emit_req;
  logic [7:0]    emit_byte;
  logic          cap;

  assign take_bit = rx_ena && (state_q != S_IDLE);
  assign new_sh   = {rx_bit, sh_q[7:1]};
  assign crc5_nx  = {crc5_q[3:0], 1'b0} ^ (5'h05 & {5{crc5_q[4] ^ rx_bit}});
  assign crc16_nx = {crc16_q[14:0], 1'b0} ^ (16'h8005 & {16{crc16_q[15] ^ rx_bit}});
  assign cap      = (ecnt_q == LW'(MAX_DATA));

  // With stripping, a byte is released only once two newer bytes exist, so the CRC pair never leaves.
  generate
    if (STRIP_CRC != 0) begin : g_strip
      assign emit_req  = (nbody_q >= 11'd2);
      assign emit_byte = dl1_q;
    end else begin : g_pass
      assign emit_req  = 1'b1;
      assign emit_byte = new_sh;
    end
  endgenerate

  always_comb begin
    logic [1:0] cls;
    logic       e_len, e_align, e_crc, e_pid;
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    nbody_d   = nbody_q;
    pid_ok_d  = pid_ok_q;
    ovf_d     = ovf_q;
    crc5_d    = crc5_q;
    crc16_d   = crc16_q;
    b0_d      = b0_q;
    dl0_d     = dl0_q;
    dl1_d     = dl1_q;
    ecnt_d    = ecnt_q;
    pid_d     = pid_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    frame_d   = frame_q;
    byte_en_d = 1'b0;
    byte_d    = byte_q;
    fin_d     = 1'b0;
    okay_d    = okay_q;
    err_d     = err_q;
    len_d     = len_q;
    cls       = 2'b00;
    e_len     = 1'b0;
    e_align   = 1'b0;
    e_crc     = 1'b0;
    e_pid     = 1'b0;

    if (rx_sta) begin
      state_d  = S_PID;
      bcnt_d   = 3'd0;
      sh_d     = 8'h00;
      nbody_d  = 11'd0;
      pid_ok_d = 1'b0;
      ovf_d    = 1'b0;
      crc5_d   = 5'h1F;
      crc16_d  = 16'hFFFF;
      b0_d     = 8'h00;
      dl0_d    = 8'h00;
      dl1_d    = 8'h00;
      ecnt_d   = '0;
      pid_d    = 4'h0;
      okay_d   = 1'b0;
      err_d    = 4'h0;
      len_d    = '0;
    end else begin
      if (take_bit) begin
        sh_d   = new_sh;
        bcnt_d = bcnt_q + 3'd1;
        if (state_q == S_BODY) begin
          crc5_d  = crc5_nx;
          crc16_d = crc16_nx;
        end
        if (bcnt_q == 3'd7) begin
          if (state_q == S_PID) begin
            state_d = S_BODY;
            if (new_sh[7:4] == ~new_sh[3:0]) begin
              pid_ok_d = 1'b1;
              pid_d    = new_sh[3:0];
            end
          end else begin
            nbody_d = (&nbody_q) ? nbody_q : nbody_q + 11'd1;
            dl0_d   = new_sh;
            dl1_d   = dl0_q;
            if (nbody_q == 11'd0) b0_d = new_sh;
            // Token fields span body bits [10:0]: all of byte 0 plus the low 3 bits of byte 1.
            if (pid_ok_q && pid_q[1:0] == 2'b01 && nbody_q == 11'd1) begin
              if (pid_q == 4'b0101) begin
                frame_d = {new_sh[2:0], b0_q};
              end else begin
                addr_d = b0_q[6:0];
                endp_d = {new_sh[2:0], b0_q[7]};
              end
            end
            if (pid_ok_q && pid_q[1:0] == 2'b11 && emit_req) begin
              if (cap) begin
                ovf_d = 1'b1;
              end else begin
                byte_en_d = 1'b1;
                byte_d    = emit_byte;
                ecnt_d    = ecnt_q + LW'(1);
              end
            end
          end
        end
      end

      // Finalise from the post-bit values so a bit arriving with rx_fin is counted.
      if (rx_fin && state_q != S_IDLE) begin
        state_d = S_IDLE;
        fin_d   = 1'b1;
        cls     = pid_d[1:0];
        e_pid   = !pid_ok_d || (cls == 2'b00);
        e_align = (bcnt_d != 3'd0);
        e_len   = ovf_d;
        if (pid_ok_d) begin
          case (cls)
            2'b01: begin
              e_len = e_len | (nbody_d != 11'd2);
              e_crc = (crc5_d != 5'h0C);
            end
            2'b10: e_len = e_len | (nbody_d != 11'd0);
            2'b11: begin
              e_len = e_len | (nbody_d < 11'd2);
              e_crc = (crc16_d != 16'h800D);
            end
            default: ;
          endcase
        end
        err_d  = {e_len, e_align, e_crc, e_pid};
        okay_d = !(e_len || e_align || e_crc || e_pid);
        len_d  = ecnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      bcnt_q    <= 3'd0;
      sh_q      <= 8'h00;
      nbody_q   <= 11'd0;
      pid_ok_q  <= 1'b0;
      ovf_q     <= 1'b0;
      crc5_q    <= 5'h1F;
      crc16_q   <= 16'hFFFF;
      b0_q      <= 8'h00;
      dl0_q     <= 8'h00;
      dl1_q     <= 8'h00;
      ecnt_q    <= '0;
      pid_q     <= 4'h0;
      addr_q    <= 7'h00;
      endp_q    <= 4'h0;
      frame_q   <= 11'h000;
      byte_en_q <= 1'b0;
      byte_q    <= 8'h00;
      fin_q     <= 1'b0;
      okay_q    <= 1'b0;
      err_q     <= 4'h0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      sh_q      <= sh_d;
      nbody_q   <= nbody_d;
      pid_ok_q  <= pid_ok_d;
      ovf_q     <= ovf_d;
      crc5_q    <= crc5_d;
      crc16_q   <= crc16_d;
      b0_q      <= b0_d;
      dl0_q     <= dl0_d;
      dl1_q     <= dl1_d;
      ecnt_q    <= ecnt_d;
      pid_q     <= pid_d;
      addr_q    <= addr_d;
      endp_q    <= endp_d;
      frame_q   <= frame_d;
      byte_en_q <= byte_en_d;
      byte_q    <= byte_d;
      fin_q     <= fin_d;
      okay_q    <= okay_d;
      err_q     <= err_d;
      len_q     <= len_d;
    end
  end

  assign rp_pid     = pid_q;
  assign rp_addr    = addr_q;
  assign rp_endp    = endp_q;
  assign rp_frame   = frame_q;
  assign rp_byte_en = byte_en_q;
  assign rp_byte    = byte_q;
  assign rp_fin     = fin_q;
  assign rp_okay    = okay_q;
  assign rp_err     = err_q;
  assign rp_len     = len_q;

endmodule

// File: tb/tb_usbfs_packet_parser.sv
// Directed bench for usbfs_packet_parser: a default instance (MAX_DATA=64, CRC stripped) and a
// small pass-through instance (MAX_DATA=4, STRIP_CRC=0) share one stimulus stream.
module tb_usbfs_packet_parser;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx_sta = 1'b0, rx_ena = 1'b0, rx_bit = 1'b0, rx_fin = 1'b0;

  logic [3:0]  a_pid, b_pid;
  logic [6:0]  a_addr, b_addr;
  logic [3:0]  a_endp, b_endp;
  logic [10:0] a_frame, b_frame;
  logic        a_byte_en, b_byte_en;
  logic [7:0]  a_byte, b_byte;
  logic        a_fin, b_fin;
  logic        a_okay, b_okay;
  logic [3:0]  a_err, b_err;
  logic [6:0]  a_len;
  logic [2:0]  b_len;

  int vectors = 0;
  int miscompares = 0;

  usbfs_packet_parser u_a (
    .clk(clk), .rstn(rstn), .rx_sta(rx_sta), .rx_ena(rx_ena), .rx_bit(rx_bit), .rx_fin(rx_fin),
    .rp_pid(a_pid), .rp_addr(a_addr), .rp_endp(a_endp), .rp_frame(a_frame),
    .rp_byte_en(a_byte_en), .rp_byte(a_byte), .rp_fin(a_fin), .rp_okay(a_okay),
    .rp_err(a_err), .rp_len(a_len)
  );

  usbfs_packet_parser #(.MAX_DATA(4), .STRIP_CRC(0)) u_b (
    .clk(clk), .rstn(rstn), .rx_sta(rx_sta), .rx_ena(rx_ena), .rx_bit(rx_bit), .rx_fin(rx_fin),
    .rp_pid(b_pid), .rp_addr(b_addr), .rp_endp(b_endp), .rp_frame(b_frame),
    .rp_byte_en(b_byte_en), .rp_byte(b_byte), .rp_fin(b_fin), .rp_okay(b_okay),
    .rp_err(b_err), .rp_len(b_len)
  );

  always #5 clk = ~clk;

  // Strobe/end-of-packet recorders, sampled mid-cycle.
  int a_nstb = 0, b_nstb = 0, a_nfin = 0, b_nfin = 0;
  logic [7:0] a_log [0:255];
  logic [7:0] b_log [0:255];

  always @(negedge clk) begin
    if (a_byte_en) begin
      a_log[a_nstb[7:0]] <= a_byte;
      a_nstb <= a_nstb + 1;
    end
    if (b_byte_en) begin
      b_log[b_nstb[7:0]] <= b_byte;
      b_nstb <= b_nstb + 1;
    end
    if (a_fin) a_nfin <= a_nfin + 1;
    if (b_fin) b_nfin <= b_nfin + 1;
  end

  logic [7:0] pl [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    rx_sta = 1'b1;
    tick();
    rx_sta = 1'b0;
  endtask

  task automatic put_bit(input logic b);
    rx_ena = 1'b1;
    rx_bit = b;
    tick();
    rx_ena = 1'b0;
    rx_bit = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) put_bit(v[i]);
  endtask

  // rp_fin is recorded by the monitor during the second tick.
  task automatic finish();
    rx_fin = 1'b1;
    tick();
    rx_fin = 1'b0;
    tick();
  endtask

  function automatic logic [4:0] crc5_of(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ (5'h05 & {5{c[4] ^ d[i]}});
    return c;
  endfunction

  function automatic logic [15:0] crc16_of(input int n);
    logic [15:0] c;
    logic [7:0]  v;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      v = pl[k];
      for (int j = 0; j < 8; j++) c = {c[14:0], 1'b0} ^ (16'h8005 & {16{c[15] ^ v[j]}});
    end
    return c;
  endfunction

  // Sends PID + 11 field bits + inverted CRC5 (MSB first); leaves the packet open.
  task automatic send_token(input logic [3:0] pid, input logic [10:0] d, input logic flip);
    logic [4:0] t;
    t = ~crc5_of(d);
    start();
    put_byte({~pid, pid});
    for (int i = 0; i < 11; i++) put_bit(d[i]);
    for (int i = 4; i >= 0; i--) put_bit(t[i] ^ (flip && i == 0));
  endtask

  task automatic send_data(input logic [3:0] pid, input int n, input logic flip);
    logic [15:0] t;
    t = ~crc16_of(n);
    start();
    put_byte({~pid, pid});
    for (int k = 0; k < n; k++) put_byte(pl[k]);
    for (int i = 15; i >= 0; i--) put_bit(t[i] ^ (flip && i == 3));
    finish();
  endtask

  int fb, sa, sb;

  initial begin
    // Reset
    tick(); tick();
    chk("rst_pid", a_pid, 4'h0);
    chk("rst_fields", {a_addr, a_endp, a_frame}, 22'h0);
    chk("rst_stream", {a_byte_en, a_byte, a_fin}, 10'h0);
    chk("rst_status", {a_okay, a_err, a_len}, 12'h0);
    rstn = 1'b1;
    tick();

    // OUT token addr 3A endp 2; fields must be visible right after the last bit
    fb = a_nfin;
    send_token(4'h1, {4'h2, 7'h3A}, 1'b0);
    chk("tok_addr_early", a_addr, 7'h3A);
    chk("tok_fin_early", a_nfin - fb, 0);
    finish();
    chk("tok_fin_cnt", a_nfin - fb, 1);
    chk("tok_pid", a_pid, 4'h1);
    chk("tok_endp", a_endp, 4'h2);
    chk("tok_okay", a_okay, 1'b1);
    chk("tok_err", a_err, 4'b0000);
    chk("tok_frame", a_frame, 11'h000);

    // Same token with one CRC bit flipped
    send_token(4'h1, {4'h2, 7'h3A}, 1'b1);
    finish();
    chk("tokbad_okay", a_okay, 1'b0);
    chk("tokbad_err", a_err, 4'b0010);

    // SOF frame 7FF leaves addr/endp alone
    send_token(4'h5, 11'h7FF, 1'b0);
    finish();
    chk("sof_frame", a_frame, 11'h7FF);
    chk("sof_okay", a_okay, 1'b1);
    chk("sof_addr", a_addr, 7'h3A);
    chk("sof_endp", a_endp, 4'h2);

    // DATA0, 8 payload bytes 01..08
    for (int k = 0; k < 8; k++) pl[k] = 8'(k + 1);
    sa = a_nstb; sb = b_nstb;
    send_data(4'h3, 8, 1'b0);
    chk("d0_pid", a_pid, 4'h3);
    chk("d0_nstb", a_nstb - sa, 8);
    for (int k = 0; k < 8; k++) chk("d0_byte", a_log[8'(sa + k)], 8'(k + 1));
    chk("d0_len", a_len, 7'd8);
    chk("d0_okay", a_okay, 1'b1);
    chk("d0_err", a_err, 4'b0000);
    chk("d0_b_nstb", b_nstb - sb, 4);
    chk("d0_b_byte3", b_log[8'(sb + 3)], 8'h04);
    chk("d0_b_len", b_len, 3'd4);
    chk("d0_b_err", b_err, 4'b1000);
    chk("d0_b_okay", b_okay, 1'b0);

    // DATA1, 6 payload bytes 10..15: saturates the MAX_DATA=4 instance
    for (int k = 0; k < 6; k++) pl[k] = 8'(8'h10 + k);
    sa = a_nstb; sb = b_nstb;
    send_data(4'hB, 6, 1'b0);
    chk("d1_b_nstb", b_nstb - sb, 4);
    chk("d1_b_byte0", b_log[8'(sb)], 8'h10);
    chk("d1_b_byte3", b_log[8'(sb + 3)], 8'h13);
    chk("d1_b_len", b_len, 3'd4);
    chk("d1_b_err", b_err, 4'b1000);
    chk("d1_b_okay", b_okay, 1'b0);
    chk("d1_a_len", a_len, 7'd6);
    chk("d1_a_okay", a_okay, 1'b1);

    // DATA0 with 2 payload bytes: pass-through instance emits exactly MAX_DATA bytes
    pl[0] = 8'hAA; pl[1] = 8'h55;
    sa = a_nstb; sb = b_nstb;
    send_data(4'h3, 2, 1'b0);
    chk("d2_a_nstb", a_nstb - sa, 2);
    chk("d2_a_byte1", a_log[8'(sa + 1)], 8'h55);
    chk("d2_b_nstb", b_nstb - sb, 4);
    chk("d2_b_len", b_len, 3'd4);
    chk("d2_b_okay", b_okay, 1'b1);

    // DATA0 with corrupted CRC16
    send_data(4'h3, 2, 1'b1);
    chk("d3_err", a_err, 4'b0010);
    chk("d3_okay", a_okay, 1'b0);

    // Bad PID byte FF
    start();
    put_byte(8'hFF);
    finish();
    chk("bad_pid", a_pid, 4'h0);
    chk("bad_err", a_err, 4'b0001);
    chk("bad_okay", a_okay, 1'b0);

    // ACK plus 3 stray bits
    start();
    put_byte(8'hD2);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    finish();
    chk("ack3_pid", a_pid, 4'h2);
    chk("ack3_err", a_err, 4'b0100);
    chk("ack3_okay", a_okay, 1'b0);

    // ACK followed by an extra full byte
    start();
    put_byte(8'hD2);
    put_byte(8'h00);
    finish();
    chk("ack9_err", a_err, 4'b1000);

    // Restart mid data packet, then a clean ACK
    fb = a_nfin;
    start();
    put_byte(8'hC3);
    put_byte(8'h01);
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    start();
    put_byte(8'hD2);
    finish();
    chk("rs_fin_cnt", a_nfin - fb, 1);
    chk("rs_pid", a_pid, 4'h2);
    chk("rs_okay", a_okay, 1'b1);
    chk("rs_err", a_err, 4'b0000);

    // Synchronous reset in the middle of a packet
    start();
    put_byte(8'hC3);
    put_byte(8'h12);
    rstn = 1'b0;
    tick();
    chk("mrst_pid", a_pid, 4'h0);
    chk("mrst_fields", {a_addr, a_endp, a_frame}, 22'h0);
    chk("mrst_stream", {a_byte_en, a_byte, a_fin}, 10'h0);
    chk("mrst_status", {a_okay, a_err, a_len}, 12'h0);
    rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
